// File: rtl/sprite_palette_unit_if.sv
// Sprite palette bus: lookup request, palette write port, flash controls and colour result.
// Latency: none, this is wiring only.
// Backpressure: none; the consumer accepts one pixel per cycle.
interface sprite_palette_if #(
    parameter int INDEX_W   = 3,
    parameter int NUM_BANKS = 4,
    parameter int COLOR_W   = 4
);
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    // Lookup request
    logic                   pix_valid_in;
    logic [INDEX_W-1:0]     pix_index;
    logic [BANK_W-1:0]      pix_bank;

    // Palette write port
    logic                   wr_en;
    logic [BANK_W-1:0]      wr_bank;
    logic [INDEX_W-1:0]     wr_addr;
    logic [3*COLOR_W-1:0]   wr_data;

    // Flash effect timing
    logic                   frame_tick;
    logic                   flash_start;

    // Lookup result
    logic [COLOR_W-1:0]     red;
    logic [COLOR_W-1:0]     green;
    logic [COLOR_W-1:0]     blue;
    logic                   pix_valid_out;
    logic                   transparent;
    logic                   flash_active;

    // Sprite fetch side: drives requests and writes, observes colours
    modport master (
        output pix_valid_in, pix_index, pix_bank,
        output wr_en, wr_bank, wr_addr, wr_data,
        output frame_tick, flash_start,
        input  red, green, blue, pix_valid_out, transparent, flash_active
    );

    // Palette unit side
    modport slave (
        input  pix_valid_in, pix_index, pix_bank,
        input  wr_en, wr_bank, wr_addr, wr_data,
        input  frame_tick, flash_start,
        output red, green, blue, pix_valid_out, transparent, flash_active
    );
endinterface

// File: rtl/sprite_palette_unit.sv
// Sprite colour lookup: palette index -> RGB from runtime-loadable banks, with transparency key and hit-flash.
// Latency: 2 cycles from a sampled request to the registered colour outputs.
// Backpressure: none; one pixel accepted every cycle, the pipeline never stalls or bubbles.
module sprite_palette_unit #(
    parameter int           INDEX_W         = 3,
    parameter int           NUM_BANKS       = 4,
    parameter int           COLOR_W         = 4,
    parameter int           TRANSPARENT_IDX = 0,
    parameter logic [7:0]   FLASH_FRAMES    = 8'd32,
    parameter int           FLASH_SHIFT     = 2
) (
    input  logic            Clk,
    input  logic            Reset_n,
    sprite_palette_if.slave bus
);
    localparam int BANK_W  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int ENTRIES = 2 ** INDEX_W;
    localparam int RGB_W   = 3 * COLOR_W;

    // One extra bit so NUM_BANKS itself is representable for the range check.
    localparam logic [BANK_W:0]    BANK_LIMIT = (BANK_W + 1)'(NUM_BANKS);
    localparam logic [INDEX_W-1:0] KEY_IDX    = INDEX_W'(TRANSPARENT_IDX);

    // Left-align a 4-bit reset nibble into a COLOR_W channel, zero-filling
    // below it (or keeping only its top bits when channels are narrower).
    function automatic logic [COLOR_W-1:0] widen_nib(input logic [3:0] nib);
        logic [COLOR_W+3:0] wide;
        wide = {nib, {COLOR_W{1'b0}}};
        return wide[COLOR_W+3 -: COLOR_W];
    endfunction

    // Power-up palette: bank 0 holds the default green-hero colours.
    function automatic logic [RGB_W-1:0] reset_entry(input int bank, input int idx);
        logic [11:0] base;
        base = 12'h000;
        if (bank == 0) begin
            case (idx)
                0:       base = 12'hD30;
                1:       base = 12'h0E0;
                2:       base = 12'h000;
                3:       base = 12'h04E;
                4:       base = 12'hECA;
                5:       base = 12'h080;
                6:       base = 12'h026;
                7:       base = 12'h977;
                default: base = 12'h000;
            endcase
        end
        return {widen_nib(base[11:8]), widen_nib(base[7:4]), widen_nib(base[3:0])};
    endfunction

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } flash_state_t;

    // Palette storage
    logic [RGB_W-1:0]   r_pal [NUM_BANKS][ENTRIES];

    // Flash control
    flash_state_t       r_flash_state;
    flash_state_t       w_flash_state_nxt;
    logic [7:0]         r_flash_cnt;
    logic [7:0]         w_flash_cnt_nxt;
    logic               w_flash_phase;

    // Stage 1: raw palette entry plus per-pixel decisions
    logic               r_s1_vld;
    logic [RGB_W-1:0]   r_s1_rgb;
    logic               r_s1_transp;
    logic               r_s1_flash;

    // Stage 2: final colour
    logic               r_s2_vld;
    logic [RGB_W-1:0]   r_s2_rgb;
    logic               r_s2_transp;

    logic               w_wr_ok;
    logic               w_rd_ok;
    logic [RGB_W-1:0]   w_rd_rgb;
    logic               w_is_key;
    logic               w_force;

    assign w_wr_ok  = bus.wr_en && ({1'b0, bus.wr_bank} < BANK_LIMIT);
    assign w_rd_ok  = ({1'b0, bus.pix_bank} < BANK_LIMIT);
    assign w_is_key = (bus.pix_index == KEY_IDX);

    // Blink phase is judged on the counter value present when the pixel is sampled.
    assign w_flash_phase = (r_flash_state == ST_ACTIVE) && r_flash_cnt[FLASH_SHIFT];

    // Transparent pixels keep their colour so the key survives a flash.
    assign w_force = r_s1_flash && !r_s1_transp;

    // Palette read; banks that do not exist read as black.
    always_comb begin
        w_rd_rgb = '0;
        if (w_rd_ok) begin
            w_rd_rgb = r_pal[bus.pix_bank][bus.pix_index];
        end
    end

    // Palette write port; reset restores the power-up palette.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                for (int i = 0; i < ENTRIES; i++) begin
                    r_pal[b][i] <= reset_entry(b, i);
                end
            end
        end else if (w_wr_ok) begin
            r_pal[bus.wr_bank][bus.wr_addr] <= bus.wr_data;
        end
    end

    // Flash state and counter registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_flash_state <= ST_IDLE;
            r_flash_cnt   <= 8'd0;
        end else begin
            r_flash_state <= w_flash_state_nxt;
            r_flash_cnt   <= w_flash_cnt_nxt;
        end
    end

    // Flash next state: a start (re)loads and beats a coincident tick; ticks count down to zero and stop.
    always_comb begin
        w_flash_cnt_nxt   = r_flash_cnt;
        w_flash_state_nxt = r_flash_state;
        if (bus.flash_start) begin
            w_flash_cnt_nxt = FLASH_FRAMES;
        end else if (bus.frame_tick && (r_flash_cnt != 8'd0)) begin
            w_flash_cnt_nxt = r_flash_cnt - 8'd1;
        end
        case (r_flash_state)
            ST_IDLE: begin
                if (w_flash_cnt_nxt != 8'd0) begin
                    w_flash_state_nxt = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (w_flash_cnt_nxt == 8'd0) begin
                    w_flash_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_flash_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Stage 1: capture the entry (before any same-edge write lands), key compare and blink phase.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_s1_vld    <= 1'b0;
            r_s1_rgb    <= '0;
            r_s1_transp <= 1'b0;
            r_s1_flash  <= 1'b0;
        end else begin
            r_s1_vld <= bus.pix_valid_in;
            if (bus.pix_valid_in) begin
                r_s1_rgb    <= w_rd_rgb;
                r_s1_transp <= w_is_key;
                r_s1_flash  <= w_flash_phase;
            end else begin
                r_s1_rgb    <= '0;
                r_s1_transp <= 1'b0;
                r_s1_flash  <= 1'b0;
            end
        end
    end

    // Stage 2: apply the flash override; invalid slots present black and not transparent.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_s2_vld    <= 1'b0;
            r_s2_rgb    <= '0;
            r_s2_transp <= 1'b0;
        end else begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_s2_rgb    <= w_force ? {RGB_W{1'b1}} : r_s1_rgb;
                r_s2_transp <= r_s1_transp;
            end else begin
                r_s2_rgb    <= '0;
                r_s2_transp <= 1'b0;
            end
        end
    end

    assign bus.red           = r_s2_rgb[RGB_W-1 -: COLOR_W];
    assign bus.green         = r_s2_rgb[2*COLOR_W-1 -: COLOR_W];
    assign bus.blue          = r_s2_rgb[COLOR_W-1:0];
    assign bus.pix_valid_out = r_s2_vld;
    assign bus.transparent   = r_s2_transp;
    assign bus.flash_active  = (r_flash_state == ST_ACTIVE);
endmodule

// File: tb/tb_sprite_palette_unit.sv
// Bench for sprite_palette_unit with three banks, so bank 3 is out of range.
// Reference model: plain palette array, integer flash counter and a one-deep result delay.
// Directed phases pin the model with hand-computed literal colours.
module tb_sprite_palette_unit;
    localparam int NB = 3;
    localparam logic [11:0] DEF_PAL [8] = '{12'hD30, 12'h0E0, 12'h000, 12'h04E,
                                            12'hECA, 12'h080, 12'h026, 12'h977};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    sprite_palette_if #(.INDEX_W(3), .NUM_BANKS(NB), .COLOR_W(4)) bus ();

    sprite_palette_unit #(
        .INDEX_W(3), .NUM_BANKS(NB), .COLOR_W(4), .TRANSPARENT_IDX(0),
        .FLASH_FRAMES(8'd32), .FLASH_SHIFT(2)
    ) dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [11:0] m_pal [NB][8];
    int          m_cnt;
    logic [13:0] m_d1;   // {valid, transparent, rgb} sampled at the last edge
    logic [13:0] m_out;  // what the outputs must show now
    logic [11:0] m_col;
    logic        m_tr;
    logic [12:0] obs_q [$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < NB; b++)
                for (int i = 0; i < 8; i++)
                    m_pal[b][i] = (b == 0) ? DEF_PAL[i] : 12'h000;
            m_cnt = 0;
            m_d1  = '0;
            m_out = '0;
        end else begin
            m_out = m_d1;
            if (bus.pix_valid_in) begin
                m_tr  = (bus.pix_index == 3'd0);
                m_col = 12'h000;
                if (int'(bus.pix_bank) < NB) m_col = m_pal[bus.pix_bank][bus.pix_index];
                if (m_cnt > 0 && ((m_cnt / 4) % 2) == 1 && !m_tr) m_col = 12'hFFF;
                m_d1 = {1'b1, m_tr, m_col};
            end else begin
                m_d1 = '0;
            end
            if (bus.wr_en && int'(bus.wr_bank) < NB) m_pal[bus.wr_bank][bus.wr_addr] = bus.wr_data;
            if (bus.flash_start) m_cnt = 32;
            else if (bus.frame_tick && m_cnt > 0) m_cnt = m_cnt - 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle: outputs against the model; keep valid results for literal checks.
    always @(negedge clk) begin
        check("pipe_out",
              32'({bus.pix_valid_out, bus.transparent, bus.red, bus.green, bus.blue, bus.flash_active}),
              32'({m_out, (m_cnt != 0)}));
        if (rst_n && bus.pix_valid_out)
            obs_q.push_back({bus.transparent, bus.red, bus.green, bus.blue});
    end

    task automatic check_obs(input string name, input int k, input logic [12:0] exp);
        if (k < obs_q.size()) begin
            check(name, 32'(obs_q[k]), 32'(exp));
        end else begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: no output at slot %0d, expected %h", name, k, exp);
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.pix_valid_in = 1'b0;
        bus.pix_index    = 3'd0;
        bus.pix_bank     = 2'd0;
        bus.wr_en        = 1'b0;
        bus.wr_bank      = 2'd0;
        bus.wr_addr      = 3'd0;
        bus.wr_data      = 12'h000;
        bus.frame_tick   = 1'b0;
        bus.flash_start  = 1'b0;
    endtask

    task automatic lookup(input int bank, input int idx);
        bus.pix_valid_in = 1'b1;
        bus.pix_bank     = 2'(bank);
        bus.pix_index    = 3'(idx);
        step();
        bus.pix_valid_in = 1'b0;
    endtask

    task automatic tick();
        bus.frame_tick = 1'b1;
        step();
        bus.frame_tick = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        repeat (3) step();
        check("reset_state",
              32'({bus.pix_valid_out, bus.transparent, bus.red, bus.green, bus.blue, bus.flash_active}),
              32'd0);
        rst_n = 1'b1;
        step();

        // Default bank 0 sweep, back to back
        obs_q.delete();
        for (int i = 0; i < 8; i++) lookup(0, i);
        repeat (2) step();
        check("sweep_count", 32'(obs_q.size()), 32'd8);
        for (int i = 0; i < 8; i++) check_obs("sweep_entry", i, {(i == 0), DEF_PAL[i]});

        // Write with same-cycle and next-cycle lookups
        obs_q.delete();
        bus.wr_en = 1'b1; bus.wr_bank = 2'd2; bus.wr_addr = 3'd5; bus.wr_data = 12'hF0F;
        lookup(2, 5);
        bus.wr_en = 1'b0;
        lookup(2, 5);
        lookup(0, 5);
        repeat (2) step();
        check_obs("wr_same_cycle", 0, 13'h0000);
        check_obs("wr_next_cycle", 1, 13'h0F0F);
        check_obs("wr_bank0_kept", 2, 13'h0080);

        // Flash over 32 frames
        obs_q.delete();
        bus.flash_start = 1'b1; step(); bus.flash_start = 1'b0;
        check("flash_active_rise", 32'(bus.flash_active), 32'd1);
        for (int t = 1; t <= 32; t++) begin
            tick();
            if (t == 31) check("flash_hold_31", 32'(bus.flash_active), 32'd1);
            if (t == 32) check("flash_drop_32", 32'(bus.flash_active), 32'd0);
            lookup(0, 1);
            lookup(0, 0);
        end
        repeat (2) step();
        check_obs("flash_cnt31", 0,  13'h0FFF);
        check_obs("flash_cnt28", 6,  13'h0FFF);
        check_obs("flash_cnt27", 8,  13'h00E0);
        check_obs("flash_cnt24", 14, 13'h00E0);
        check_obs("flash_cnt4",  54, 13'h0FFF);
        check_obs("flash_cnt3",  56, 13'h00E0);
        check_obs("flash_cnt0",  62, 13'h00E0);
        for (int t = 1; t <= 32; t++) check_obs("flash_key_unforced", 2 * t - 1, 13'h1D30);

        // Start coincident with tick while count is 3
        obs_q.delete();
        bus.flash_start = 1'b1; step(); bus.flash_start = 1'b0;
        repeat (29) tick();
        bus.flash_start = 1'b1; bus.frame_tick = 1'b1;
        step();
        bus.flash_start = 1'b0; bus.frame_tick = 1'b0;
        lookup(0, 1);
        tick();
        lookup(0, 1);
        repeat (30) tick();
        check("coinc_hold", 32'(bus.flash_active), 32'd1);
        tick();
        check("coinc_drop", 32'(bus.flash_active), 32'd0);
        check_obs("coinc_load32", 0, 13'h00E0);
        check_obs("coinc_dec31", 1, 13'h0FFF);

        // Out-of-range bank write and read
        obs_q.delete();
        bus.wr_en = 1'b1; bus.wr_bank = 2'd3; bus.wr_addr = 3'd1; bus.wr_data = 12'hABC;
        step();
        bus.wr_en = 1'b0;
        lookup(3, 1);
        lookup(3, 0);
        lookup(0, 1);
        lookup(2, 1);
        repeat (2) step();
        check_obs("oor_read", 0, 13'h0000);
        check_obs("oor_key", 1, 13'h1000);
        check_obs("oor_bank0", 2, 13'h00E0);
        check_obs("oor_bank2", 3, 13'h0000);

        // Reset with two pixels in flight
        lookup(0, 3);
        lookup(0, 4);
        check("inflight_valid", 32'(bus.pix_valid_out), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_async",
              32'({bus.pix_valid_out, bus.transparent, bus.red, bus.green, bus.blue, bus.flash_active}),
              32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        obs_q.delete();
        lookup(2, 5);
        lookup(0, 5);
        repeat (2) step();
        check("post_rst_count", 32'(obs_q.size()), 32'd2);
        check_obs("post_rst_write_lost", 0, 13'h0000);
        check_obs("post_rst_bank0", 1, 13'h0080);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
